// File: rtl/patch_reducer_scheduler.sv
// patch_reducer_scheduler
//   Controller for a bank of patch row reducers. Configuration records are
//   taken from an upstream queue and handed to the lowest-index free reducer
//   with a one-cycle init pulse. Finished row sums are collected round-robin,
//   forwarded downstream with the producing reducer's index, and then acked.
//   Each reducer is tracked as busy from dispatch until its sum is acked.
//
// Ports
//   dram_clk      sole clock, rising edge
//   reset_n       asynchronous active-low reset
//   cfg_valid     upstream record valid
//   cfg_ready     a reducer is free, record accepted this cycle if valid
//   cfg_topbtm    {do_top,do_btm} forwarded on the target's init pair
//   cfg_data      record payload, broadcast to all reducers
//   init          per-reducer init, bits [2i+1:2i], one-cycle pulse
//   config_data   registered copy of the last dispatched cfg_data
//   sum_rdy       per-reducer sum ready, bits [2i+1:2i], nonzero = ready
//   sum           per-reducer sums, slice i
//   sum_ack       one-cycle ack to the reducer whose sum was delivered
//   out_valid     collected sum valid
//   out_ready     downstream accepts
//   out_sum       collected sum
//   out_reducer   index of the reducer that produced out_sum
//   busy          reducer configured and not yet acked
//   n_dispatched  records dispatched, wraps
//   n_collected   sums delivered, wraps
//   idle          no busy reducer and no pending output
module patch_reducer_scheduler #(
  parameter int APP_DATA_WIDTH  = 256,
  parameter int N_PATCH_REDUCER = 4,
  parameter int ROW_SUM_SIZE    = 32,
  parameter int CNT_SIZE        = 16,
  localparam int IDX_W          = $clog2(N_PATCH_REDUCER)
) (
  input  logic                                    dram_clk,
  input  logic                                    reset_n,
  input  logic                                    cfg_valid,
  output logic                                    cfg_ready,
  input  logic [1:0]                              cfg_topbtm,
  input  logic [APP_DATA_WIDTH-1:0]               cfg_data,
  output logic [2*N_PATCH_REDUCER-1:0]            init,
  output logic [APP_DATA_WIDTH-1:0]               config_data,
  input  logic [2*N_PATCH_REDUCER-1:0]            sum_rdy,
  input  logic [ROW_SUM_SIZE*N_PATCH_REDUCER-1:0] sum,
  output logic [N_PATCH_REDUCER-1:0]              sum_ack,
  output logic                                    out_valid,
  input  logic                                    out_ready,
  output logic [ROW_SUM_SIZE-1:0]                 out_sum,
  output logic [IDX_W-1:0]                        out_reducer,
  output logic [N_PATCH_REDUCER-1:0]              busy,
  output logic [CNT_SIZE-1:0]                     n_dispatched,
  output logic [CNT_SIZE-1:0]                     n_collected,
  output logic                                    idle
);

  localparam int unsigned NR = N_PATCH_REDUCER;

  localparam logic [1:0] C_SCAN = 2'd0;
  localparam logic [1:0] C_HOLD = 2'd1;
  localparam logic [1:0] C_ACK  = 2'd2;

  logic [1:0]                       r_state;
  logic [N_PATCH_REDUCER-1:0]       r_busy;
  logic [2*N_PATCH_REDUCER-1:0]     r_init;
  logic [APP_DATA_WIDTH-1:0]        r_config_data;
  logic [N_PATCH_REDUCER-1:0]       r_sum_ack;
  logic                             r_out_valid;
  logic [ROW_SUM_SIZE-1:0]          r_out_sum;
  logic [IDX_W-1:0]                 r_out_reducer;
  logic [IDX_W-1:0]                 r_rr_ptr;
  logic [CNT_SIZE-1:0]              r_n_disp;
  logic [CNT_SIZE-1:0]              r_n_coll;

  logic [N_PATCH_REDUCER-1:0]       w_free;
  logic                             w_disp;
  logic [IDX_W-1:0]                 w_tgt;
  logic                             w_tgt_found;
  logic [N_PATCH_REDUCER-1:0]       w_cand;
  logic [IDX_W-1:0]                 w_pick;
  logic                             w_found;
  int unsigned                      w_idx;
  logic [ROW_SUM_SIZE-1:0]          w_sums [N_PATCH_REDUCER];
  logic [2*N_PATCH_REDUCER-1:0]     w_init_nxt;
  logic [N_PATCH_REDUCER-1:0]       w_set;
  logic [N_PATCH_REDUCER-1:0]       w_clr;
  logic [N_PATCH_REDUCER-1:0]       w_ack_nxt;
  logic                             w_out_hs;

  assign w_free    = ~r_busy;
  assign cfg_ready = |w_free;
  assign w_disp    = cfg_valid && cfg_ready;
  assign w_out_hs  = (r_state == C_HOLD) && r_out_valid && out_ready;

  // Lowest-index free reducer receives the next record.
  always_comb begin
    w_tgt       = '0;
    w_tgt_found = 1'b0;
    for (int unsigned k = 0; k < NR; k++) begin
      if (!w_tgt_found && w_free[k[IDX_W-1:0]]) begin
        w_tgt       = IDX_W'(k);
        w_tgt_found = 1'b1;
      end
    end
  end

  // Per-reducer decode; the C_ACK clear always targets a busy reducer, which
  // can never be the dispatch target, so set and clear never hit one bit.
  for (genvar g = 0; g < N_PATCH_REDUCER; g++) begin : g_red
    assign w_cand[g]            = r_busy[g] && (|sum_rdy[2*g +: 2]);
    assign w_sums[g]            = sum[g*ROW_SUM_SIZE +: ROW_SUM_SIZE];
    assign w_set[g]             = w_disp && (w_tgt == IDX_W'(g));
    assign w_clr[g]             = (r_state == C_ACK) && (r_out_reducer == IDX_W'(g));
    assign w_ack_nxt[g]         = w_out_hs && (r_out_reducer == IDX_W'(g));
    assign w_init_nxt[2*g +: 2] = w_set[g] ? cfg_topbtm : 2'b00;
  end

  // First candidate at or after the round-robin pointer, wrapping modulo N.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = 0;
    for (int unsigned k = 0; k < NR; k++) begin
      w_idx = int'(r_rr_ptr) + k;
      if (w_idx >= NR) w_idx = w_idx - NR;
      if (!w_found && w_cand[w_idx[IDX_W-1:0]]) begin
        w_found = 1'b1;
        w_pick  = IDX_W'(w_idx);
      end
    end
  end

  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_init        <= '0;
      r_config_data <= '0;
      r_n_disp      <= '0;
      r_busy        <= '0;
    end else begin
      r_init <= w_init_nxt;
      r_busy <= (r_busy | w_set) & ~w_clr;
      if (w_disp) begin
        r_config_data <= cfg_data;
        r_n_disp      <= r_n_disp + CNT_SIZE'(1);
      end
    end
  end

  always_ff @(posedge dram_clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state       <= C_SCAN;
      r_sum_ack     <= '0;
      r_out_valid   <= 1'b0;
      r_out_sum     <= '0;
      r_out_reducer <= '0;
      r_rr_ptr      <= '0;
      r_n_coll      <= '0;
    end else begin
      case (r_state)
        C_SCAN: begin
          if (w_found) begin
            r_out_sum     <= w_sums[w_pick];
            r_out_reducer <= w_pick;
            r_out_valid   <= 1'b1;
            r_state       <= C_HOLD;
          end
        end
        C_HOLD: begin
          if (w_out_hs) begin
            r_out_valid <= 1'b0;
            r_sum_ack   <= w_ack_nxt;
            r_n_coll    <= r_n_coll + CNT_SIZE'(1);
            r_rr_ptr    <= (r_out_reducer == IDX_W'(NR - 1)) ? '0
                                                             : r_out_reducer + IDX_W'(1);
            r_state     <= C_ACK;
          end
        end
        C_ACK: begin
          r_sum_ack <= '0;
          r_state   <= C_SCAN;
        end
        default: r_state <= C_SCAN;
      endcase
    end
  end

  assign init         = r_init;
  assign config_data  = r_config_data;
  assign sum_ack      = r_sum_ack;
  assign out_valid    = r_out_valid;
  assign out_sum      = r_out_sum;
  assign out_reducer  = r_out_reducer;
  assign busy         = r_busy;
  assign n_dispatched = r_n_disp;
  assign n_collected  = r_n_coll;
  assign idle         = (r_busy == '0) && !r_out_valid;

endmodule

// File: tb/tb_patch_reducer_scheduler.sv
// tb_patch_reducer_scheduler
//   Directed scenarios followed by randomized dispatch/collect rounds. The
//   reference keeps per-reducer busy/ready state and a round-robin pointer
//   and predicts which reducer is served next and what every output shows.
module tb_patch_reducer_scheduler;

  localparam int N  = 4;
  localparam int DW = 256;
  localparam int SW = 32;
  localparam int CW = 4;

  logic              dram_clk = 1'b0;
  logic              reset_n;
  logic              cfg_valid;
  logic              cfg_ready;
  logic [1:0]        cfg_topbtm;
  logic [DW-1:0]     cfg_data;
  logic [2*N-1:0]    init;
  logic [DW-1:0]     config_data;
  logic [2*N-1:0]    sum_rdy;
  logic [SW*N-1:0]   sum;
  logic [N-1:0]      sum_ack;
  logic              out_valid;
  logic              out_ready;
  logic [SW-1:0]     out_sum;
  logic [1:0]        out_reducer;
  logic [N-1:0]      busy;
  logic [CW-1:0]     n_dispatched;
  logic [CW-1:0]     n_collected;
  logic              idle;

  always #5 dram_clk = ~dram_clk;

  patch_reducer_scheduler #(
    .APP_DATA_WIDTH (DW),
    .N_PATCH_REDUCER(N),
    .ROW_SUM_SIZE   (SW),
    .CNT_SIZE       (CW)
  ) dut (
    .dram_clk    (dram_clk),
    .reset_n     (reset_n),
    .cfg_valid   (cfg_valid),
    .cfg_ready   (cfg_ready),
    .cfg_topbtm  (cfg_topbtm),
    .cfg_data    (cfg_data),
    .init        (init),
    .config_data (config_data),
    .sum_rdy     (sum_rdy),
    .sum         (sum),
    .sum_ack     (sum_ack),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_sum     (out_sum),
    .out_reducer (out_reducer),
    .busy        (busy),
    .n_dispatched(n_dispatched),
    .n_collected (n_collected),
    .idle        (idle)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // Reference state
  bit            m_busy [N];
  int            m_code [N];
  logic [SW-1:0] m_sum  [N];
  int            m_rr;
  int            m_disp;
  int            m_coll;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge dram_clk);
    @(negedge dram_clk);
  endtask

  function automatic logic [N-1:0] busy_vec();
    logic [N-1:0] v;
    for (int i = 0; i < N; i++) v[i] = m_busy[i];
    return v;
  endfunction

  function automatic int free_target();
    for (int i = 0; i < N; i++) if (!m_busy[i]) return i;
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int k = 0; k < DW / 32; k++) d[32*k +: 32] = $urandom;
    return d;
  endfunction

  task automatic drive_reducers();
    for (int i = 0; i < N; i++) begin
      sum[SW*i +: SW]   = m_sum[i];
      sum_rdy[2*i +: 2] = 2'(m_code[i]);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_busy[i] = 0;
      m_code[i] = 0;
      m_sum[i]  = '0;
    end
    m_rr = 0; m_disp = 0; m_coll = 0;
  endtask

  // Presents a record (left valid on return) and checks the one-edge dispatch.
  task automatic dispatch(input logic [1:0] tb_bits, input logic [DW-1:0] d);
    int t;
    logic [2*N-1:0] exp_init;
    cfg_valid  = 1'b1;
    cfg_topbtm = tb_bits;
    cfg_data   = d;
    t = free_target();
    chk("cfg_ready_pre", cfg_ready, t >= 0);
    step();
    exp_init = '0;
    if (t >= 0) begin
      exp_init[2*t +: 2] = tb_bits;
      m_busy[t] = 1;
      m_disp++;
    end
    chk("init", init, exp_init);
    chk("config_data", config_data, d);
    chk("busy_disp", busy, busy_vec());
    chk("n_dispatched", n_dispatched, m_disp % (1 << CW));
  endtask

  // Collects the next sum the reference predicts, with hold cycles of backpressure.
  task automatic collect(input int hold);
    int w, idx, cnt;
    logic [N-1:0] ack_exp;
    w = -1;
    for (int k = 0; k < N; k++) begin
      idx = (m_rr + k) % N;
      if (w < 0 && m_busy[idx] && m_code[idx] != 0) w = idx;
    end
    if (w < 0) begin
      n_assert++; n_fail++;
      $error("FAIL collect_pred: observed no candidate expected one");
      return;
    end
    out_ready = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 8) begin
      step();
      cnt++;
    end
    chk("out_valid_rise", out_valid, 1'b1);
    chk("out_reducer", out_reducer, w);
    chk("out_sum", out_sum, m_sum[w]);
    chk("sum_ack_hold", sum_ack, '0);
    for (int h = 0; h < hold; h++) begin
      step();
      chk("bp_valid", out_valid, 1'b1);
      chk("bp_sum", out_sum, m_sum[w]);
      chk("bp_reducer", out_reducer, w);
      chk("bp_ack", sum_ack, '0);
    end
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    m_coll++;
    ack_exp = '0;
    ack_exp[w] = 1'b1;
    chk("out_valid_drop", out_valid, 1'b0);
    chk("sum_ack", sum_ack, ack_exp);
    chk("n_collected", n_collected, m_coll % (1 << CW));
    chk("busy_at_ack", busy, busy_vec());
    chk("cfg_ready_at_ack", cfg_ready, free_target() >= 0);
    m_code[w] = 0;
    drive_reducers();
    step();
    m_busy[w] = 0;
    m_rr = (w + 1) % N;
    chk("sum_ack_clear", sum_ack, '0);
    chk("busy_cleared", busy, busy_vec());
    chk("cfg_ready_free", cfg_ready, 1'b1);
    chk("idle", idle, busy_vec() == '0);
  endtask

  function automatic bit any_ready();
    for (int i = 0; i < N; i++) if (m_busy[i] && m_code[i] != 0) return 1;
    return 0;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [DW-1:0] rec [5];
    logic [1:0]    tbb [5];
    int nd;

    reset_n = 1'b0; cfg_valid = 1'b0; cfg_topbtm = 2'b00; cfg_data = '0;
    sum_rdy = '0; sum = '0; out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge dram_clk);
    reset_n = 1'b1;
    step();

    // Reset state
    chk("rst_init", init, '0);
    chk("rst_config_data", config_data, '0);
    chk("rst_sum_ack", sum_ack, '0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_sum", out_sum, '0);
    chk("rst_out_reducer", out_reducer, '0);
    chk("rst_busy", busy, '0);
    chk("rst_n_disp", n_dispatched, '0);
    chk("rst_n_coll", n_collected, '0);
    chk("rst_idle", idle, 1'b1);
    chk("rst_cfg_ready", cfg_ready, 1'b1);

    // Fill: four back-to-back dispatches, fifth record held upstream
    for (int r = 0; r < 5; r++) begin
      rec[r] = rand_data();
      tbb[r] = 2'($urandom_range(1, 3));
    end
    for (int r = 0; r < 4; r++) dispatch(tbb[r], rec[r]);
    cfg_topbtm = tbb[4];
    cfg_data   = rec[4];
    chk("full_cfg_ready", cfg_ready, 1'b0);
    step();
    chk("full_init", init, '0);
    chk("full_busy", busy, 4'hF);
    chk("full_n_disp", n_dispatched, 4);
    chk("full_config_data", config_data, rec[3]);

    // Recycle reducer 0 while the fifth record waits
    m_code[0] = 1; m_sum[0] = $urandom;
    drive_reducers();
    collect(0);
    dispatch(tbb[4], rec[4]);
    cfg_valid = 1'b0;
    chk("recycle_n_disp", n_dispatched, 5);

    // Backpressure on reducer 1, which moves the pointer to 2
    m_code[1] = 3; m_sum[1] = $urandom;
    drive_reducers();
    collect(10);
    dispatch(2'b10, rand_data());
    cfg_valid = 1'b0;

    // Round-robin from pointer 2 with reducers 1 and 3 ready
    m_code[1] = 1; m_sum[1] = 32'd100;
    m_code[3] = 2; m_sum[3] = 32'd300;
    drive_reducers();
    collect(0);
    collect(0);

    // Spurious ready from non-busy reducer 2
    m_code[2] = 1; m_sum[2] = $urandom;
    drive_reducers();
    collect(0);
    m_code[2] = 1;
    drive_reducers();
    for (int c = 0; c < 4; c++) begin
      step();
      chk("spur_out_valid", out_valid, 1'b0);
      chk("spur_sum_ack", sum_ack, '0);
    end
    m_code[2] = 0;
    drive_reducers();

    // Randomized rounds
    for (int it = 0; it < 30; it++) begin
      nd = $urandom_range(0, N);
      for (int j = 0; j < nd; j++)
        if (free_target() >= 0) dispatch(2'($urandom_range(1, 3)), rand_data());
      cfg_valid = 1'b0;
      for (int i = 0; i < N; i++) begin
        if (m_busy[i]) begin
          if ($urandom_range(0, 1) == 1) begin
            m_code[i] = $urandom_range(1, 3);
            m_sum[i]  = $urandom;
          end
        end else if ($urandom_range(0, 3) == 0) begin
          m_code[i] = $urandom_range(1, 3);
          m_sum[i]  = $urandom;
        end
      end
      drive_reducers();
      while (any_ready()) collect($urandom_range(0, 3));
      for (int i = 0; i < N; i++) if (!m_busy[i]) m_code[i] = 0;
      drive_reducers();
      step();
      chk("rand_out_valid_idle", out_valid, 1'b0);
    end

    // Drain, then assert reset in the middle of a held output
    for (int i = 0; i < N; i++) if (m_busy[i]) begin
      m_code[i] = 1; m_sum[i] = $urandom;
    end
    drive_reducers();
    while (any_ready()) collect($urandom_range(0, 2));
    dispatch(2'b11, rand_data());
    cfg_valid = 1'b0;
    m_code[0] = 2; m_sum[0] = $urandom;
    drive_reducers();
    out_ready = 1'b0;
    repeat (3) step();
    chk("pre_rst_out_valid", out_valid, 1'b1);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_busy", busy, '0);
    chk("midrst_sum_ack", sum_ack, '0);
    chk("midrst_idle", idle, 1'b1);
    chk("midrst_n_disp", n_dispatched, '0);
    model_reset();
    drive_reducers();
    @(negedge dram_clk);
    reset_n = 1'b1;
    step();
    chk("post_rst_idle", idle, 1'b1);
    chk("post_rst_cfg_ready", cfg_ready, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
